// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM states, access-size encodings and helpers for dmem_responder
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = 4;

  // Reserved size 11 counts as misaligned so it can never touch memory
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM with byte write enables and registered read
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        if (i_be[0]) r_mem[i_addr][7:0]   <= i_wdata[7:0];
        if (i_be[1]) r_mem[i_addr][15:8]  <= i_wdata[15:8];
        if (i_be[2]) r_mem[i_addr][23:16] <= i_wdata[23:16];
        if (i_be[3]) r_mem[i_addr][31:24] <= i_wdata[31:24];
      end else begin
        o_rdata <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder with lane steering
// Optional DMEM_ERR_EN: flag misaligned/reserved accesses with err and suppress their effects.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [11:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_we;
  logic [11:0]      r_addr;
  logic [1:0]       r_size;
  logic [31:0]      r_wdata;
  logic             r_ack, r_err;

  logic             w_accept, w_enter_resp, w_mis;
  logic             w_ram_en, w_ram_we;
  logic [AW-1:0]    w_ram_addr;
  logic [3:0]       w_be;
  logic [31:0]      w_wd, w_q, w_rd_lane;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt  = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt  = ST_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_enter_resp;
      r_err   <= w_enter_resp & w_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= we;
      r_addr  <= addr;
      r_size  <= size;
      r_wdata <= wdata;
    end
  end

`ifdef DMEM_ERR_EN
  // When entering RESP straight from IDLE the capture registers are not loaded yet
  logic [1:0] w_cur_size, w_cur_lo;
  assign w_cur_size = (r_state == ST_IDLE) ? size : r_size;
  assign w_cur_lo   = (r_state == ST_IDLE) ? addr[1:0] : r_addr[1:0];
  assign w_mis      = is_misaligned(w_cur_size, w_cur_lo);
  assign err        = r_err;
`else
  assign w_mis = 1'b0;
  assign err   = 1'b0;
`endif

  always_comb begin
    w_be      = 4'b1111;
    w_wd      = r_wdata;
    w_rd_lane = w_q;
    case (r_size)
      SZ_BYTE: begin
        w_be      = 4'b0001 << r_addr[1:0];
        w_wd      = {4{r_wdata[7:0]}};
        w_rd_lane = {24'h0, w_q[{r_addr[1:0], 3'b000} +: 8]};
      end
      SZ_HALF: begin
        w_be      = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wd      = {2{r_wdata[15:0]}};
        w_rd_lane = {16'h0, w_q[{r_addr[1], 4'b0000} +: 16]};
      end
      default: ;
    endcase
  end

  // Write commits on the edge leaving RESP; a reset on that edge drops it
  assign w_ram_we   = (r_state == ST_RESP) & r_we & ~r_err & rst;
  assign w_ram_en   = w_enter_resp | w_ram_we;
  assign w_ram_addr = (r_state == ST_IDLE) ? addr[2 +: AW] : r_addr[2 +: AW];

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_be    (w_be),
    .i_addr  (w_ram_addr),
    .i_wdata (w_wd),
    .o_rdata (w_q)
  );

  assign ack   = r_ack;
  assign rdata = (r_ack && !r_err) ? w_rd_lane : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder against a memory model
module tb_dmem_responder;

  localparam int WC = 2;

  logic        clk;
  logic        rst;
  logic        req, we;
  logic [11:0] addr;
  logic [1:0]  size;
  logic [31:0] wdata, rdata;
  logic        ack, err;

  logic        req0, we0;
  logic [11:0] addr0;
  logic [1:0]  size0;
  logic [31:0] wdata0, rdata0;
  logic        ack0, err0;

  int n_total = 0;
  int n_bad   = 0;

  bit [31:0] m_mem [1024];

  dmem_responder #(.WAIT_CYCLES(WC), .DEPTH_WORDS(1024)) u_dut (
    .clk (clk), .rst (rst), .req (req), .we (we), .addr (addr), .size (size),
    .wdata (wdata), .rdata (rdata), .ack (ack), .err (err)
  );

  dmem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(1024)) u_dut0 (
    .clk (clk), .rst (rst), .req (req0), .we (we0), .addr (addr0), .size (size0),
    .wdata (wdata0), .rdata (rdata0), .ack (ack0), .err (err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit m_mis(input bit [1:0] sz, input bit [11:0] a);
`ifdef DMEM_ERR_EN
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
`else
    return (sz == 2'd3) && (a == 12'hFFF) && 1'b0;
`endif
  endfunction

  function automatic bit [31:0] m_read(input bit [1:0] sz, input bit [11:0] a);
    bit [31:0] w;
    w = m_mem[(a / 4) % 1024];
    case (sz)
      2'd0:    return (w >> (8 * (a % 4))) & 32'hFF;
      2'd1:    return (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  task automatic m_write(input bit [1:0] sz, input bit [11:0] a, input bit [31:0] wd);
    int i, sh;
    bit [31:0] w, mask;
    i = (a / 4) % 1024;
    w = m_mem[i];
    case (sz)
      2'd0:    begin sh = 8 * (a % 4);         mask = 32'hFF << sh; end
      2'd1:    begin sh = 16 * ((a / 2) % 2);  mask = 32'hFFFF << sh; end
      default: begin sh = 0;                   mask = 32'hFFFF_FFFF; end
    endcase
    m_mem[i] = (w & ~mask) | ((wd << sh) & mask);
  endtask

  task automatic txn(input bit t_we, input bit [1:0] t_sz, input bit [11:0] t_a,
                     input bit [31:0] t_wd, output bit [31:0] got);
    bit [31:0] exp_rd;
    bit        exp_er;
    int        lat;
    exp_er = m_mis(t_sz, t_a);
    exp_rd = exp_er ? 32'h0 : m_read(t_sz, t_a);
    @(negedge clk);
    req = 1'b1; we = t_we; addr = t_a; size = t_sz; wdata = t_wd;
    lat = 0;
    got = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        lat = c;
        got = rdata;
        check("err", {31'h0, err}, {31'h0, exp_er});
        break;
      end
    end
    req = 1'b0; we = 1'b0; addr = 12'($urandom); size = 2'($urandom); wdata = $urandom;
    check("latency", lat, WC + 1);
    if (!t_we) check("rdata", got, exp_rd);
    if (t_we && !exp_er) m_write(t_sz, t_a, t_wd);
    @(negedge clk);
    check("ack_pulse", {31'h0, ack}, 32'h0);
    check("rdata_idle", rdata, 32'h0);
  endtask

  task automatic abort_txn(input bit [11:0] t_a, input bit [31:0] t_wd, input int at_cycle);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = t_a; size = 2'd2; wdata = t_wd;
    for (int c = 1; c < at_cycle; c++) begin
      @(negedge clk);
      seen |= ack;
    end
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0; we = 1'b0;
    repeat (3) begin @(negedge clk); seen |= ack; end
    rst = 1'b1;
    repeat (3) begin @(negedge clk); seen |= ack; end
    check($sformatf("abort_ack_c%0d", at_cycle), {31'h0, seen}, 32'h0);
  endtask

  task automatic txn0(input bit t_we, input bit [11:0] t_a, input bit [31:0] t_wd,
                      output bit [31:0] got, output int lat);
    @(negedge clk);
    req0 = 1'b1; we0 = t_we; addr0 = t_a; size0 = 2'd2; wdata0 = t_wd;
    lat = 0;
    got = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ack0 === 1'b1) begin lat = c; got = rdata0; break; end
    end
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit [31:0] got, v;
    bit        a0 [1:5];
    int        lat, idx;

    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; size = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; size0 = '0; wdata0 = '0;
    repeat (3) @(negedge clk);
    req = 1'b1; req0 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ack0", {31'h0, ack0}, 32'h0);
    req = 1'b0; req0 = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 32; i++) begin
      idx = (i < 16) ? i : 1008 + i - 16;
      txn(1'b1, 2'd2, 12'(idx * 4), $urandom, got);
    end

    // abort in WAIT and in RESP: neither write may land
    abort_txn(12'h010, 32'hBAD0_0010, 1);
    txn(1'b0, 2'd2, 12'h010, 32'h0, got);
    abort_txn(12'h014, 32'hBAD0_0014, 3);
    txn(1'b0, 2'd2, 12'h014, 32'h0, got);

    txn(1'b1, 2'd2, 12'h004, 32'hDEADBEEF, got);
    txn(1'b0, 2'd2, 12'h004, 32'h0, got);
    check("w_rd_deadbeef", got, 32'hDEADBEEF);
    txn(1'b1, 2'd0, 12'h006, 32'h0000005A, got);
    txn(1'b0, 2'd2, 12'h004, 32'h0, got);
    check("b_rd_word", got, 32'hDE5ABEEF);
    txn(1'b0, 2'd1, 12'h006, 32'h0, got);
    check("h_rd_half", got, 32'h0000DE5A);

    txn(1'b1, 2'd2, 12'h005, 32'hA5A5A5A5, got);
    txn(1'b0, 2'd2, 12'h004, 32'h0, got);
`ifdef DMEM_ERR_EN
    check("mis_unchanged", got, 32'hDE5ABEEF);
`else
    check("mis_written", got, 32'hA5A5A5A5);
`endif

    v = m_mem[0];
    txn(1'b1, 2'd2, 12'hFFC, 32'h11223344, got);
    txn(1'b0, 2'd2, 12'h000, 32'h0, got);
    check("wrap_w0", got, v);
    txn(1'b0, 2'd2, 12'hFFC, 32'h0, got);
    check("wrap_ffc", got, 32'h11223344);

    for (int n = 0; n < 150; n++) begin
      idx = $urandom_range(0, 31);
      idx = (idx < 16) ? idx : 1008 + idx - 16;
      txn(1'(($urandom)), 2'($urandom), 12'(idx * 4 + $urandom_range(0, 3)), $urandom, got);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    // zero-wait instance: req held high gives ack every other cycle
    txn0(1'b1, 12'h008, 32'hCAFEF00D, got, lat);
    check("w0_wr_lat", lat, 1);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h008; size0 = 2'd2;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      a0[c] = ack0;
      if (c == 1) check("w0_rd_data", rdata0, 32'hCAFEF00D);
      if (c == 3) req0 = 1'b0;
    end
    check("w0_ack_c1", {31'h0, a0[1]}, 32'h1);
    check("w0_ack_c2", {31'h0, a0[2]}, 32'h0);
    check("w0_ack_c3", {31'h0, a0[3]}, 32'h1);
    check("w0_ack_c4", {31'h0, a0[4]}, 32'h0);
    check("w0_ack_c5", {31'h0, a0[5]}, 32'h0);
    txn0(1'b0, 12'h008, 32'h0, got, lat);
    check("w0_rd_lat", lat, 1);
    check("w0_rd_again", got, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the number of wait states inserted between request accept and response (legal 0..15).
REQ-002 Parameter DEPTH_WORDS, default 1024, SHALL set the 32-bit word capacity (4 KB).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-low reset.
REQ-005 req  input  1  SHALL be the request valid from the CPU side, held high until ack.
REQ-006 we  input  1  SHALL select write (1) or read (0).
REQ-007 addr  input  12  SHALL be the byte address; bits [11:2] select the word.
REQ-008 size  input  2  SHALL encode the access width: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 wdata  input  32  SHALL carry write data, right-justified.
REQ-010 rdata  output  32  SHALL carry read data, right-justified and zero-extended, valid only while ack=1.
REQ-011 ack  output  1  SHALL be a registered one-cycle completion pulse.
REQ-012 err  output  1  SHALL be a registered error flag, valid only while ack=1.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-014 In IDLE with req=1, the block SHALL capture we/addr/size/wdata and go to WAIT with counter=WAIT_CYCLES-1, or straight to RESP if WAIT_CYCLES=0.
REQ-015 WAIT SHALL decrement the counter and go to RESP when the counter reaches 0; inputs SHALL be ignored while in WAIT.
REQ-016 ack SHALL be 1 exactly while in RESP; RESP SHALL always return to IDLE on the next edge.
REQ-017 Latency from the accept edge to ack high SHALL be WAIT_CYCLES+1 cycles.
REQ-018 Back-to-back requests SHALL be spaced by at least one IDLE cycle; req still high in the cycle after ack SHALL start a new transaction.
REQ-019 Memory SHALL be little-endian: byte lane k = addr[1:0] maps to bits [8k+7:8k], and half lane h = addr[1] maps to bits [16h+15:16h].
REQ-020 A write SHALL update only the addressed lanes, using the captured wdata low bits, on the edge leaving RESP.
REQ-021 rdata SHALL be loaded on the edge entering RESP and SHALL read 0 outside RESP.
REQ-022 A read of a location written by the immediately preceding transaction SHALL return the new data.
REQ-023 Addresses SHALL wrap modulo DEPTH_WORDS*4.

Reset
REQ-024 While rst=0 at an edge, the FSM SHALL go to IDLE with ack=0, err=0, rdata=0 and counter=0.
REQ-025 Reset in WAIT or RESP SHALL abort the transaction and drop any pending write.
REQ-026 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With DMEM_ERR_EN defined, the following SHALL be flagged misaligned: a half access with addr[0]=1, a word access with addr[1:0]!=0, and size=11.
REQ-028 For a misaligned access, the block SHALL set err=1 with ack, suppress the write and force rdata=0, with the same latency as a normal access.
REQ-029 Without DMEM_ERR_EN, err SHALL be tied to 0, low address bits below the access width SHALL be ignored, and size=11 SHALL be treated as word.

Structure
REQ-030 Package dmem_pkg SHALL hold the FSM state enum, the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the WAIT counter width (4).
REQ-031 Storage SHALL be a sub-module dmem_ram: DEPTH_WORDS x 32, single port, 4-bit byte write enable, synchronous read.
REQ-032 Lane steering and FSM logic SHALL live in dmem_responder.

Verification
REQ-033 Reset mid-WAIT: write to 0x010 aborted by rst=0 -> ack never asserted; a later word read of 0x010 returns the old value.
REQ-034 Word write then read, WAIT_CYCLES=2: write 0xDEADBEEF to 0x004, then word read of 0x004 -> ack 3 cycles after accept, rdata=0xDEADBEEF.
REQ-035 Byte and half access: byte write 0x5A to 0x006, then word read of 0x004 -> 0xDE5ABEEF; half read of 0x006 -> 0x0000DE5A.
REQ-036 WAIT_CYCLES=0 with req held high for two reads -> ack on cycles 1 and 3 after the first accept, never on consecutive cycles.
REQ-037 Misalignment with DMEM_ERR_EN: word write to 0x005 -> ack with err=1, memory unchanged; without DMEM_ERR_EN the same write updates word 0x004.
REQ-038 Wrap-around: word write 0x11223344 to 0xFFC, then word read of 0x000 -> value unchanged, and a read of 0xFFC -> 0x11223344.
